// File: rtl/lfsr_rng_stream.sv
// Streaming LFSR random-word generator: Fibonacci or Galois stepping with a
// runtime tap mask, several steps per word, seed load over a handshake,
// automatic all-zero lock-up recovery and full-period detection.
module lfsr_rng_stream #(
  parameter int               WIDTH        = 32,
  parameter int               STEPS        = 1,
  parameter int               GALOIS       = 0,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'({32{2'b10}}),
  parameter logic [WIDTH-1:0] DEFAULT_TAPS = WIDTH'(32'h80200003),
  parameter int               CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] seed_i,
  input  logic [WIDTH-1:0] taps_i,
  input  logic             seed_valid_i,
  output logic             seed_ready_o,
  input  logic             enable_i,
  output logic [WIDTH-1:0] rnd_o,
  output logic             rnd_valid_o,
  input  logic             rnd_ready_i,
  output logic             lockup_o,
  output logic             period_o,
  output logic [CNT_W-1:0] cnt_o
);

  typedef enum logic {ST_RUN, ST_RELOAD} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] seed_r_q;
  logic [WIDTH-1:0] taps_q;
  logic [WIDTH-1:0] rnd_q;
  logic             rnd_valid_q;
  logic             lockup_q;
  logic             period_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] adv_d;
  logic             fire;
  logic             accept;
  logic             seed_acc;

  // One LFSR advance with the currently captured tap mask.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v,
                                                 input logic [WIDTH-1:0] t);
    if (GALOIS != 0)
      return {1'b0, v[WIDTH-1:1]} ^ ({WIDTH{v[0]}} & t);
    else
      return {^(v & t), v[WIDTH-1:1]};
  endfunction

  // STEPS chained advances, all resolved within a single cycle.
  always_comb begin
    adv_d = s_q;
    for (int k = 0; k < STEPS; k++) begin
      adv_d = lfsr_step(adv_d, taps_q);
    end
  end

  assign fire     = enable_i && (!rnd_valid_q || rnd_ready_i);
  assign accept   = rnd_valid_q && rnd_ready_i;
  assign seed_acc = seed_valid_i && (state_q == ST_RUN);

  // Control FSM plus all datapath state; seed load outranks generation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_RUN;
      s_q         <= DEFAULT_SEED;
      seed_r_q    <= DEFAULT_SEED;
      taps_q      <= DEFAULT_TAPS;
      rnd_q       <= '0;
      rnd_valid_q <= 1'b0;
      lockup_q    <= 1'b0;
      period_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      lockup_q <= 1'b0;
      period_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (seed_acc) begin
            // A pending word is dropped uncounted and the count restarts.
            s_q         <= seed_i;
            seed_r_q    <= seed_i;
            taps_q      <= (taps_i == '0) ? DEFAULT_TAPS : taps_i;
            rnd_valid_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= ST_RELOAD;
          end else begin
            if (accept) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
            if (fire) begin
              if (s_q == '0) begin
                // Lock-up: recover without emitting; any accepted word retires.
                s_q         <= DEFAULT_SEED;
                lockup_q    <= 1'b1;
                rnd_valid_q <= 1'b0;
              end else begin
                rnd_q       <= s_q;
                rnd_valid_q <= 1'b1;
                s_q         <= adv_d;
                if (adv_d == seed_r_q) begin
                  period_q <= 1'b1;
                end
              end
            end else if (accept) begin
              rnd_valid_q <= 1'b0;
            end
          end
        end
        ST_RELOAD: begin
          state_q <= ST_RUN;
          if (s_q == '0) begin
            s_q      <= DEFAULT_SEED;
            seed_r_q <= DEFAULT_SEED;
            lockup_q <= 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign seed_ready_o = (state_q == ST_RUN);
  assign rnd_o        = rnd_q;
  assign rnd_valid_o  = rnd_valid_q;
  assign lockup_o     = lockup_q;
  assign period_o     = period_q;
  assign cnt_o        = cnt_q;

endmodule

// File: tb/tb_lfsr_rng_stream.sv
// Scoreboard bench for lfsr_rng_stream: five configurations share one clock
// and reset; expected words are queued as stimulus is driven and popped as
// the selected instance hands words over.
module tb_lfsr_rng_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] seed_bus = '0;
  logic [31:0] taps_bus = '0;
  logic [4:0]  sv = '0;
  logic        enable = 1'b0;
  logic        ready = 1'b0;

  logic [7:0]  r0, r1, r2;
  logic [3:0]  r3;
  logic [31:0] r4;
  logic [4:0]  srdy, vld, lck, per;
  logic [15:0] cnt_w [5];
  logic [31:0] rnd_w [5];

  int          sel = 0;
  logic [31:0] exp_q [$];
  logic [31:0] e_word;
  logic [31:0] hold_exp;
  int          checks = 0;
  int          errors = 0;
  int          per_cnt = 0;
  int          lck_cnt = 0;
  logic [31:0] per_word = '0;

  always #5 clk = ~clk;

  always_comb begin
    rnd_w[0] = {24'd0, r0};
    rnd_w[1] = {24'd0, r1};
    rnd_w[2] = {24'd0, r2};
    rnd_w[3] = {28'd0, r3};
    rnd_w[4] = r4;
  end

  lfsr_rng_stream #(.WIDTH(8)) u_f8 (
    .clk_i(clk), .rst_ni(rst_n), .seed_i(seed_bus[7:0]), .taps_i(taps_bus[7:0]),
    .seed_valid_i(sv[0]), .seed_ready_o(srdy[0]), .enable_i(enable),
    .rnd_o(r0), .rnd_valid_o(vld[0]), .rnd_ready_i(ready),
    .lockup_o(lck[0]), .period_o(per[0]), .cnt_o(cnt_w[0]));

  lfsr_rng_stream #(.WIDTH(8), .STEPS(2)) u_f8s2 (
    .clk_i(clk), .rst_ni(rst_n), .seed_i(seed_bus[7:0]), .taps_i(taps_bus[7:0]),
    .seed_valid_i(sv[1]), .seed_ready_o(srdy[1]), .enable_i(enable),
    .rnd_o(r1), .rnd_valid_o(vld[1]), .rnd_ready_i(ready),
    .lockup_o(lck[1]), .period_o(per[1]), .cnt_o(cnt_w[1]));

  lfsr_rng_stream #(.WIDTH(8), .GALOIS(1)) u_g8 (
    .clk_i(clk), .rst_ni(rst_n), .seed_i(seed_bus[7:0]), .taps_i(taps_bus[7:0]),
    .seed_valid_i(sv[2]), .seed_ready_o(srdy[2]), .enable_i(enable),
    .rnd_o(r2), .rnd_valid_o(vld[2]), .rnd_ready_i(ready),
    .lockup_o(lck[2]), .period_o(per[2]), .cnt_o(cnt_w[2]));

  lfsr_rng_stream #(.WIDTH(4)) u_f4 (
    .clk_i(clk), .rst_ni(rst_n), .seed_i(seed_bus[3:0]), .taps_i(taps_bus[3:0]),
    .seed_valid_i(sv[3]), .seed_ready_o(srdy[3]), .enable_i(enable),
    .rnd_o(r3), .rnd_valid_o(vld[3]), .rnd_ready_i(ready),
    .lockup_o(lck[3]), .period_o(per[3]), .cnt_o(cnt_w[3]));

  lfsr_rng_stream #(.WIDTH(32)) u_f32 (
    .clk_i(clk), .rst_ni(rst_n), .seed_i(seed_bus), .taps_i(taps_bus),
    .seed_valid_i(sv[4]), .seed_ready_o(srdy[4]), .enable_i(enable),
    .rnd_o(r4), .rnd_valid_o(vld[4]), .rnd_ready_i(ready),
    .lockup_o(lck[4]), .period_o(per[4]), .cnt_o(cnt_w[4]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: pop on every handshake that is not discarded by a seed load.
  always @(negedge clk) begin
    if (rst_n) begin
      if (per[sel]) begin
        per_cnt++;
        per_word = rnd_w[sel];
      end
      if (lck[sel]) lck_cnt++;
      if (vld[sel] && ready && !(sv[sel] && srdy[sel])) begin
        if (exp_q.size() == 0) begin
          check("extra_word_valid", {31'd0, vld[sel]}, 32'd0);
        end else begin
          e_word = exp_q.pop_front();
          $display("txn inst=%0d rnd=%h exp=%h cnt=%0d", sel, rnd_w[sel], e_word, cnt_w[sel]);
          check("word", rnd_w[sel], e_word);
        end
      end
    end
  end

  // Seed handshake, entered at posedge+1; checks the RELOAD timing around it.
  task automatic load(input int idx, input logic [31:0] s, input logic [31:0] t);
    seed_bus = s;
    taps_bus = t;
    sel      = idx;
    per_cnt  = 0;
    lck_cnt  = 0;
    sv[idx]  = 1'b1;
    @(posedge clk); #1;
    sv[idx] = 1'b0;
    check("sready_low", {31'd0, srdy[idx]}, 32'd0);
    check("valid_cleared", {31'd0, vld[idx]}, 32'd0);
    check("cnt_cleared", {16'd0, cnt_w[idx]}, 32'd0);
    @(posedge clk); #1;
    check("sready_back", {31'd0, srdy[idx]}, 32'd1);
    check("valid_in_reload", {31'd0, vld[idx]}, 32'd0);
    @(posedge clk); #1;
    check("valid_lat2", {31'd0, vld[idx]}, {31'd0, enable});
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [3:0] seq4 [16] = '{4'h1, 4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB,
                              4'h5, 4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1};
    int n;

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      check("rst_rnd", rnd_w[i], 32'd0);
      check("rst_valid", {31'd0, vld[i]}, 32'd0);
      check("rst_sready", {31'd0, srdy[i]}, 32'd1);
      check("rst_cnt", {16'd0, cnt_w[i]}, 32'd0);
    end
    rst_n  = 1'b1;
    enable = 1'b1;
    @(posedge clk); #1;

    // Fibonacci WIDTH=8, one step per word
    ready = 1'b1;
    exp_q.delete();
    exp_q.push_back(32'hAA); exp_q.push_back(32'hD5); exp_q.push_back(32'h6A);
    load(0, 32'hAA, 32'hB8);
    drain();
    ready = 1'b0;
    check("cnt_after3", {16'd0, cnt_w[0]}, 32'd3);

    // Two steps per word
    ready = 1'b1;
    exp_q.push_back(32'hAA); exp_q.push_back(32'h6A);
    load(1, 32'hAA, 32'hB8);
    drain();
    ready = 1'b0;
    check("cnt_steps2", {16'd0, cnt_w[1]}, 32'd2);

    // Galois stepping
    ready = 1'b1;
    exp_q.push_back(32'h01); exp_q.push_back(32'hB8); exp_q.push_back(32'h5C);
    load(2, 32'h01, 32'hB8);
    drain();
    ready = 1'b0;

    // WIDTH=4 full period with a backpressure hold in the middle
    ready = 1'b1;
    for (int i = 0; i < 16; i++) exp_q.push_back({28'd0, seq4[i]});
    load(3, 32'h1, 32'h3);
    n = 0;
    while (exp_q.size() > 10 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    ready    = 1'b0;
    hold_exp = exp_q[0];
    repeat (3) begin
      @(posedge clk); #1;
      check("hold_rnd", rnd_w[3], hold_exp);
      check("hold_valid", {31'd0, vld[3]}, 32'd1);
    end
    ready = 1'b1;
    drain();
    ready = 1'b0;
    check("period_count", per_cnt, 32'd1);
    check("period_word", per_word, 32'h3);
    check("cnt_full", {16'd0, cnt_w[3]}, 32'd16);

    // Zero seed and zero taps: lock-up recovery and default taps
    ready = 1'b1;
    exp_q.push_back(32'hAAAAAAAA); exp_q.push_back(32'hD5555555);
    load(4, 32'h0, 32'h0);
    drain();
    ready = 1'b0;
    check("lockup_count", lck_cnt, 32'd1);

    // Seed load colliding with a handshake discards the pending word
    ready = 1'b1;
    exp_q.push_back(32'hAA); exp_q.push_back(32'hD5);
    load(0, 32'hAA, 32'hB8);
    drain();
    check("cnt_before_reseed", {16'd0, cnt_w[0]}, 32'd2);
    check("pending_before_reseed", {31'd0, vld[0]}, 32'd1);
    exp_q.delete();
    exp_q.push_back(32'h3C);
    load(0, 32'h3C, 32'hB8);
    drain();
    ready = 1'b0;
    check("cnt_after_reseed", {16'd0, cnt_w[0]}, 32'd1);
    check("pending_after_reseed", {31'd0, vld[0]}, 32'd1);

    // Asynchronous reset mid-stream, then restart from the default seed
    #1;
    rst_n = 1'b0;
    #1;
    check("async_valid", {31'd0, vld[0]}, 32'd0);
    check("async_cnt", {16'd0, cnt_w[0]}, 32'd0);
    check("async_sready", {31'd0, srdy[0]}, 32'd1);
    exp_q.delete();
    exp_q.push_back(32'hAA);
    rst_n = 1'b1;
    ready = 1'b1;
    drain();
    ready = 1'b0;
    check("cnt_after_restart", {16'd0, cnt_w[0]}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_rng_stream.md
Name: lfsr_rng_stream

Overview:
Parametrised, streaming successor to the single-width LFSR generator. It supports any width from 4 to 64 and runtime tap masks, with either Fibonacci or Galois stepping. It can advance several steps per output word and emits words over a valid/ready handshake. Seeds load through a handshake, all-zero lock-up recovers automatically, and full-period completion is detected; it feeds test-pattern and dither consumers.

Parameters:
WIDTH, 32, LFSR state and output width; legal 4..64.
STEPS, 1, LFSR advances per emitted word; legal 1..WIDTH.
GALOIS, 0, 0 = Fibonacci stepping, 1 = Galois stepping.
DEFAULT_SEED, alternating 1010... pattern of WIDTH bits (32'hAAAAAAAA), state loaded at reset and on lock-up; must be nonzero.
DEFAULT_TAPS, 32'h80200003, tap mask used at reset and when a zero mask is loaded.
CNT_W, 16, width of accepted-word counter.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
seed  input  WIDTH  seed value to load
taps  input  WIDTH  tap mask, captured with seed
seed_valid  input  1  seed/taps present
seed_ready  output  1  block can accept a seed
enable  input  1  permit generation of new words
rnd  output  WIDTH  random word
rnd_valid  output  1  rnd holds an unconsumed word
rnd_ready  input  1  consumer accepts rnd
lockup  output  1  one-cycle pulse: zero state replaced by DEFAULT_SEED
period  output  1  one-cycle pulse: state returned to loaded seed
cnt  output  CNT_W  accepted-word count since last seed load

Behaviour:
- Reset (reset=0, async) values:
  - s=DEFAULT_SEED, taps_r=DEFAULT_TAPS, seed_r=DEFAULT_SEED.
  - rnd=0, rnd_valid=0, lockup=0, period=0, cnt=0.
  - FSM=RUN, seed_ready=1.
- Reset deassertion mid-stream restarts exactly as from power-up.
- Fibonacci step: fb = XOR of (s & taps_r); s' = {fb, s[WIDTH-1:1]}.
- Galois step: s' = {1'b0, s[WIDTH-1:1]} XOR ({WIDTH{s[0]}} & taps_r).
- adv(s) = step applied STEPS times, combinationally within one cycle.
- FSM states RUN and RELOAD.
- RUN:
  - seed_ready=1.
  - On seed_valid&&seed_ready: s<=seed, seed_r<=seed, taps_r<=(taps==0 ? DEFAULT_TAPS : taps).
  - Same edge: rnd_valid<=0 (pending word discarded), cnt<=0, FSM->RELOAD.
  - Seed load has priority over generation and over acceptance on the same edge.
  - A discarded word is not counted.
- RELOAD (exactly one cycle):
  - seed_ready=0, no generation, FSM->RUN.
  - If s==0: s<=DEFAULT_SEED and seed_r<=DEFAULT_SEED, lockup pulses.
- Generation, in RUN with no seed accepted, when fire = enable && (!rnd_valid || rnd_ready):
  - If s==0: s<=DEFAULT_SEED, lockup pulses, no word emitted that cycle.
  - Otherwise: rnd<=s, rnd_valid<=1, s<=adv(s).
  - If adv(s)==seed_r, period pulses on the same edge.
- Latency:
  - First word equals the seed.
  - It is valid 2 cycles after the seed handshake edge (RELOAD, then generate).
  - Thereafter one word per cycle while rnd_ready=1.
- Backpressure:
  - While rnd_valid && !rnd_ready, rnd and s hold.
  - enable=0 stops new words; a pending word stays valid until accepted.
  - When rnd_valid && rnd_ready && !fire, rnd_valid<=0.
- cnt increments on each rnd_valid&&rnd_ready not coincident with a seed accept.
  - Wraps modulo 2^CNT_W.
- lockup and period are registered and high for exactly one cycle per event.

Test Plan:
1. WIDTH=8, taps=8'hB8, GALOIS=0, seed=8'hAA, enable=1, rnd_ready=1 -> words AA, D5, 6A; seed_ready low one cycle after handshake; first word 2 cycles after the handshake; cnt=3 after the third accept.
2. Same as 1, STEPS=2 -> words AA, 6A.
3. WIDTH=8, GALOIS=1, taps=8'hB8, seed=8'h01 -> words 01, B8, 5C.
4. WIDTH=4, taps=4'b0011, seed=4'h1 -> words 1,8,4,2,9,C,6,B,5,A,D,E,F,7,3, then 1.
   - period pulses exactly once, on the edge emitting 3.
   - Also hold rnd_ready=0 for 3 cycles mid-run: rnd stable, sequence unchanged.
5. Load seed=0, taps=0 (WIDTH=32) -> lockup pulse in RELOAD; taps_r=32'h80200003; first word 32'hAAAAAAAA.
6. Assert seed_valid on a cycle where rnd_valid&&rnd_ready -> word discarded, cnt=0, next word = new seed. Separately, assert reset=0 mid-stream -> rnd_valid=0 and cnt=0 immediately, without waiting for a clock edge.
